// File: rtl/aes_pkg.sv
// Shared AES definitions for the key schedule: S-box table, xtime, block size and FSM encoding.
package aes_pkg;

  localparam int unsigned Nb = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single-byte combinational AES forward S-box lookup.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y_c
);

  // Shift the wanted byte (index a from the top) down to bit 0.
  assign y_c = 8'(SBOX_TABLE >> {~a, 3'b000});

endmodule

// File: rtl/key_expansion.sv
// Iterative AES key schedule: loads Nk key words, then derives one schedule word per enabled cycle.
module key_expansion
  import aes_pkg::*;
#(
  parameter int unsigned Nk = 4,
  parameter int unsigned Nr = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   start,
  input  logic [Nk*32-1:0]       key_in,
  output logic [(Nr+1)*128-1:0]  w,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned NW = Nb * (Nr + 1);
  localparam int unsigned IW = $clog2(NW + 1);
  localparam int unsigned AW = $clog2(NW);

  state_t        state_q, state_d;
  logic [IW-1:0] i_q;
  logic [7:0]    rcon_q;
  logic [31:0]   words [NW];

  logic [IW-1:0] i_mod;
  logic [31:0]   prev, back, sub_in, sub_out, temp, new_word;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_EXPAND;
      ST_EXPAND: if (i_q == IW'(NW - 1)) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else if (en) state_q <= state_d;
  end

  // Word-wide datapath for schedule word i.
  assign i_mod  = i_q % IW'(Nk);
  assign prev   = words[AW'(i_q - IW'(1))];
  assign back   = words[AW'(i_q - IW'(Nk))];
  assign sub_in = (i_mod == '0) ? {prev[23:0], prev[31:24]} : prev;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .a   (sub_in[8*b +: 8]),
      .y_c (sub_out[8*b +: 8])
    );
  end

  always_comb begin
    temp = prev;
    if (i_mod == '0) temp = sub_out ^ {rcon_q, 24'h0};
    else if ((Nk > 6) && (i_mod == IW'(4))) temp = sub_out;
    new_word = back ^ temp;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NW; k++) words[AW'(k)] <= '0;
      i_q    <= '0;
      rcon_q <= 8'h01;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else if (en) begin
      busy <= (state_d == ST_EXPAND);
      done <= (state_d == ST_DONE);
      case (state_q)
        ST_IDLE: if (start) begin
          for (int k = 0; k < Nk; k++) words[AW'(k)] <= key_in[Nk*32-1-32*k -: 32];
          i_q    <= IW'(Nk);
          rcon_q <= 8'h01;
        end
        ST_EXPAND: begin
          words[AW'(i_q)] <= new_word;
          i_q             <= i_q + IW'(1);
          if (i_mod == '0) rcon_q <= xtime(rcon_q);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w = '0;
    for (int j = 0; j < NW; j++) w[(NW-1-j)*32 +: 32] = words[AW'(j)];
  end

endmodule

// File: tb/tb_key_expansion.sv
// Bench for key_expansion: AES-128/192/256 instances checked against a GF(2^8)-arithmetic reference schedule.
module tb_key_expansion;

  logic         clk, rst, en;
  logic [2:0]   start_v, busy_v, done_v;
  logic [127:0] k128;
  logic [191:0] k192;
  logic [255:0] k256;
  logic [1407:0] w128;
  logic [1663:0] w192;
  logic [1919:0] w256;

  int tests = 0;
  int fails = 0;

  logic [7:0]  sbox_ref [256];
  logic [31:0] ref_w [3][60];

  key_expansion #(.Nk(4), .Nr(10)) dut128 (
    .clk(clk), .rst(rst), .en(en), .start(start_v[0]), .key_in(k128),
    .w(w128), .busy(busy_v[0]), .done(done_v[0]));
  key_expansion #(.Nk(6), .Nr(12)) dut192 (
    .clk(clk), .rst(rst), .en(en), .start(start_v[1]), .key_in(k192),
    .w(w192), .busy(busy_v[1]), .done(done_v[1]));
  key_expansion #(.Nk(8), .Nr(14)) dut256 (
    .clk(clk), .rst(rst), .en(en), .start(start_v[2]), .key_in(k256),
    .w(w256), .busy(busy_v[2]), .done(done_v[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          sel;
    int          idx;
    logic [31:0] exp;
    string       name;
  } vec_t;

  function automatic int nk_of(input int sel);
    return 4 + 2 * sel;
  endfunction

  function automatic int nw_of(input int sel);
    return 4 * (nk_of(sel) + 7);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  // S-box from first principles: multiplicative inverse followed by the affine map.
  function automatic void build_sbox();
    logic [7:0] b, inv;
    for (int x = 0; x < 256; x++) begin
      b = 8'(x);
      inv = 8'h00;
      if (b != 8'h00) begin
        inv = 8'h01;
        for (int e = 0; e < 254; e++) inv = gmul(inv, b);
      end
      sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox_ref[t[31:24]], sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]]};
  endfunction

  function automatic logic [31:0] key_word(input int sel, input int k);
    case (sel)
      0:       return k128[127-32*k -: 32];
      1:       return k192[191-32*k -: 32];
      default: return k256[255-32*k -: 32];
    endcase
  endfunction

  function automatic logic [31:0] dut_word(input int sel, input int j);
    case (sel)
      0:       return w128[(43-j)*32 +: 32];
      1:       return w192[(51-j)*32 +: 32];
      default: return w256[(59-j)*32 +: 32];
    endcase
  endfunction

  function automatic void ref_expand(input int sel);
    int nk, nw;
    logic [31:0] t;
    logic [7:0] rc;
    nk = nk_of(sel);
    nw = nw_of(sel);
    for (int k = 0; k < nk; k++) ref_w[sel][k] = key_word(sel, k);
    for (int i = nk; i < nw; i++) begin
      t = ref_w[sel][i-1];
      if (i % nk == 0) begin
        rc = 8'h01;
        for (int r = 1; r < i / nk; r++) rc = gmul(rc, 8'h02);
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      ref_w[sel][i] = ref_w[sel][i-nk] ^ t;
    end
  endfunction

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic void check_sched(input int sel, input string tag);
    int bad, first;
    bad = 0; first = -1;
    for (int j = 0; j < nw_of(sel); j++)
      if (dut_word(sel, j) !== ref_w[sel][j]) begin
        bad++;
        if (first < 0) first = j;
      end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s_sched: %0d words wrong, first w[%0d] got %h expected %h",
               tag, bad, first, dut_word(sel, first), ref_w[sel][first]);
    end
  endfunction

  function automatic void rand_key(input int sel);
    case (sel)
      0:       k128 = {$urandom, $urandom, $urandom, $urandom};
      1:       k192 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      default: k256 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endcase
  endfunction

  // One full expansion; counts enabled edges from the start edge (inclusive) to done.
  task automatic run(input int sel, input bit bubbles, input bit restart, input string tag);
    int cnt, guard, exp_edges;
    bit seen;
    exp_edges = nw_of(sel) - nk_of(sel) + 1;
    @(negedge clk); en = 1'b1; start_v[sel] = 1'b1;
    @(posedge clk); cnt = 1;
    @(negedge clk); start_v[sel] = 1'b0;
    check({tag, "_busy"}, 64'(busy_v[sel]), 64'd1);
    seen = 1'b0; guard = 0;
    while (!seen && guard < 400) begin
      if (done_v[sel]) seen = 1'b1;
      else begin
        en = bubbles ? ($urandom_range(0, 3) != 0) : 1'b1;
        start_v[sel] = restart && cnt >= 17 && cnt <= 19;
        if (restart && sel == 0 && cnt == 17) k128 = ~k128;
        @(posedge clk);
        if (en) cnt++;
        guard++;
        @(negedge clk);
      end
    end
    start_v[sel] = 1'b0;
    check({tag, "_latency"}, 64'(seen ? cnt : -1), 64'(exp_edges));
    en = 1'b0;
    @(posedge clk); @(negedge clk);
    check({tag, "_done_hold"}, 64'(done_v[sel]), 64'd1);
    en = 1'b1; start_v[sel] = 1'b1;
    @(posedge clk); @(negedge clk);
    start_v[sel] = 1'b0;
    check({tag, "_done_width"}, 64'({done_v[sel], busy_v[sel]}), 64'd0);
    check_sched(sel, tag);
  endtask

  localparam logic [127:0] KEY128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] KEY192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] KEY256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  vec_t vecs [9];

  initial begin
    vecs[0] = '{0, 4,  32'ha0fafe17, "t1_w4"};
    vecs[1] = '{0, 40, 32'hd014f9a8, "t1_w40"};
    vecs[2] = '{0, 41, 32'hc9ee2589, "t1_w41"};
    vecs[3] = '{0, 42, 32'he13f0cc8, "t1_w42"};
    vecs[4] = '{0, 43, 32'hb6630ca6, "t1_w43"};
    vecs[5] = '{1, 6,  32'hfe0c91f7, "t2_w6"};
    vecs[6] = '{1, 51, 32'h01002202, "t2_w51"};
    vecs[7] = '{2, 8,  32'h9ba35411, "t3_w8"};
    vecs[8] = '{2, 59, 32'h706c631e, "t3_w59"};

    rst = 1'b0; en = 1'b0; start_v = '0;
    k128 = '0; k192 = '0; k256 = '0;
    build_sbox();
    #12;
    check("rst_w128", 64'(w128 != '0), 64'd0);
    check("rst_w192", 64'(w192 != '0), 64'd0);
    check("rst_w256", 64'(w256 != '0), 64'd0);
    check("rst_busy_done", 64'({busy_v, done_v}), 64'd0);
    rst = 1'b1;

    // Known-answer keys for all three key sizes.
    k128 = KEY128; k192 = KEY192; k256 = KEY256;
    for (int s = 0; s < 3; s++) begin
      ref_expand(s);
      run(s, 1'b0, 1'b0, $sformatf("kat%0d", s));
    end
    for (int t = 0; t < 9; t++)
      check(vecs[t].name, 64'(dut_word(vecs[t].sel, vecs[t].idx)), 64'(vecs[t].exp));

    // Random keys against the reference model, last round with en bubbles.
    for (int it = 0; it < 3; it++)
      for (int s = 0; s < 3; s++) begin
        rand_key(s);
        ref_expand(s);
        run(s, it == 2, 1'b0, $sformatf("rnd%0d_%0d", it, s));
      end

    // En bubbles on the AES-128 vector, starting from a different stored schedule.
    k128 = KEY128; ref_expand(0);
    run(0, 1'b1, 1'b0, "t4_bubble");
    check("t4_w43", 64'(dut_word(0, 43)), 64'h00000000b6630ca6);

    // Start re-asserted around i=20 while the key input changes.
    rand_key(0); ref_expand(0);
    run(0, 1'b0, 1'b0, "t5_pre");
    k128 = KEY128; ref_expand(0);
    run(0, 1'b0, 1'b1, "t5_restart");

    // Asynchronous reset between edges mid-expansion.
    rand_key(0);
    @(negedge clk); en = 1'b1; start_v[0] = 1'b1;
    @(posedge clk); @(negedge clk); start_v[0] = 1'b0;
    repeat (19) @(negedge clk);
    check("t6_busy_before", 64'(busy_v[0]), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("t6_rst_w", 64'(w128 != '0), 64'd0);
    check("t6_rst_busy", 64'(busy_v[0]), 64'd0);
    check("t6_rst_done", 64'(done_v[0]), 64'd0);
    #1 rst = 1'b1;
    k128 = KEY128; ref_expand(0);
    run(0, 1'b0, 1'b0, "t6_fresh");
    check("t6_w4", 64'(dut_word(0, 4)), 64'h00000000a0fafe17);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
